// File: rtl/insn_decode_ctrl_pkg.sv
// Shared RV32I decode definitions: opcodes, one-hot class indices, control encodings
// and the packed control bundle registered by the decode stage.
package insn_decode_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int CLS_R      = 0;
    localparam int CLS_LOAD   = 1;
    localparam int CLS_IMM    = 2;
    localparam int CLS_SYSTEM = 3;
    localparam int CLS_JALR   = 4;
    localparam int CLS_STORE  = 5;
    localparam int CLS_BRANCH = 6;
    localparam int CLS_AUIPC  = 7;
    localparam int CLS_LUI    = 8;
    localparam int CLS_JAL    = 9;
    localparam int NUM_CLS    = 10;

    typedef logic [NUM_CLS-1:0] cls_vec_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SLL    = 4'b0001,
        ALU_SLT    = 4'b0010,
        ALU_SLTU   = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SRL    = 4'b0101,
        ALU_OR     = 4'b0110,
        ALU_AND    = 4'b0111,
        ALU_SUB    = 4'b1000,
        ALU_SRA    = 4'b1101,
        ALU_PASS_B = 4'b1111
    } alu_sel_e;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } access_size_e;

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  alu_sel;
        logic [1:0]  wb_sel;
        logic        a_sel;
        logic        b_sel;
        logic        reg_we;
        logic        br_un;
        logic        mem_rw;
        logic        pc_sel;
        logic [1:0]  access_size;
        logic        load_un;
    } ctrl_t;

    function automatic cls_vec_t decode_class(input logic [6:0] op);
        cls_vec_t c;
        c = '0;
        case (op)
            OP_R:      c[CLS_R]      = 1'b1;
            OP_LOAD:   c[CLS_LOAD]   = 1'b1;
            OP_IMM:    c[CLS_IMM]    = 1'b1;
            OP_SYSTEM: c[CLS_SYSTEM] = 1'b1;
            OP_JALR:   c[CLS_JALR]   = 1'b1;
            OP_STORE:  c[CLS_STORE]  = 1'b1;
            OP_BRANCH: c[CLS_BRANCH] = 1'b1;
            OP_AUIPC:  c[CLS_AUIPC]  = 1'b1;
            OP_LUI:    c[CLS_LUI]    = 1'b1;
            OP_JAL:    c[CLS_JAL]    = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/insn_decode_ctrl_imm_gen.sv
// Combinational RV32I immediate generator driven by the one-hot class vector;
// an empty class vector (R, invalid or idle) yields zero.
module insn_imm_gen
    import insn_decode_ctrl_pkg::*;
(
    input  logic [31:0] insn,
    input  cls_vec_t    cls,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        if (cls[CLS_LOAD] | cls[CLS_IMM] | cls[CLS_JALR] | cls[CLS_SYSTEM]) begin
            imm = {{20{insn[31]}}, insn[31:20]};
        end else if (cls[CLS_STORE]) begin
            imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        end else if (cls[CLS_BRANCH]) begin
            imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        end else if (cls[CLS_AUIPC] | cls[CLS_LUI]) begin
            imm = {insn[31:12], 12'b0};
        end else if (cls[CLS_JAL]) begin
            imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        end
    end

endmodule

// File: rtl/insn_decode_ctrl.sv
// RV32I decode stage: classifies the instruction, builds datapath controls and the
// immediate, and registers everything as the decode pipeline boundary.
module insn_decode_ctrl
    import insn_decode_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] insn,
    input  logic        br_eq,
    input  logic        br_lt,
    output logic        out_valid,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [4:0]  shamt,
    output logic [31:0] imm,
    output logic [3:0]  alu_sel,
    output logic [1:0]  wb_sel,
    output logic        A_sel,
    output logic        B_sel,
    output logic        reg_write_enable,
    output logic        br_un,
    output logic        mem_rw,
    output logic        pc_sel,
    output logic [1:0]  access_size,
    output logic        load_un
);

    cls_vec_t    cls;
    logic [31:0] imm_gen;
    logic [2:0]  f3;
    logic        taken;
    logic        valid_d, valid_q;
    logic [31:0] insn_d, insn_q;
    ctrl_t       ctrl_d, ctrl_q;

    // Gating the class vector makes idle cycles decode exactly like an invalid opcode.
    assign cls = in_valid ? decode_class(insn[6:0]) : '0;
    assign f3  = insn[14:12];

    insn_imm_gen u_imm_gen (
        .insn (insn),
        .cls  (cls),
        .imm  (imm_gen)
    );

    always_comb begin
        case (f3)
            3'b000:          taken = br_eq;
            3'b001:          taken = ~br_eq;
            3'b100, 3'b110:  taken = br_lt;
            3'b101, 3'b111:  taken = ~br_lt;
            default:         taken = 1'b0;
        endcase
    end

    always_comb begin
        valid_d = in_valid;
        insn_d  = insn;
        ctrl_d  = '0;

        ctrl_d.imm = imm_gen;

        ctrl_d.alu_sel = ALU_ADD;
        if (cls[CLS_R]) begin
            ctrl_d.alu_sel = {insn[30], f3};
        end else if (cls[CLS_IMM]) begin
            // Only the shift-right pair uses funct7[5]; elsewhere insn[30] is immediate data.
            ctrl_d.alu_sel = {(f3 == 3'b101) & insn[30], f3};
        end else if (cls[CLS_LUI]) begin
            ctrl_d.alu_sel = ALU_PASS_B;
        end

        ctrl_d.a_sel = cls[CLS_BRANCH] | cls[CLS_AUIPC] | cls[CLS_JAL];
        ctrl_d.b_sel = (|cls) & ~cls[CLS_R] & ~cls[CLS_SYSTEM];

        if (cls[CLS_LOAD]) begin
            ctrl_d.wb_sel = WB_MEM;
        end else if (cls[CLS_JALR] | cls[CLS_JAL]) begin
            ctrl_d.wb_sel = WB_PC4;
        end else if ((|cls) & ~cls[CLS_SYSTEM]) begin
            ctrl_d.wb_sel = WB_ALU;
        end else begin
            ctrl_d.wb_sel = WB_MEM;
        end

        ctrl_d.reg_we = cls[CLS_R] | cls[CLS_LOAD] | cls[CLS_IMM] | cls[CLS_JALR]
                      | cls[CLS_AUIPC] | cls[CLS_LUI] | cls[CLS_JAL];
        ctrl_d.mem_rw = cls[CLS_STORE];
        ctrl_d.access_size = (cls[CLS_LOAD] | cls[CLS_STORE]) ? f3[1:0] : SIZE_BYTE;
        ctrl_d.load_un = cls[CLS_LOAD] & f3[2];
        ctrl_d.br_un   = cls[CLS_BRANCH] & f3[1];
        ctrl_d.pc_sel  = cls[CLS_JAL] | cls[CLS_JALR] | (cls[CLS_BRANCH] & taken);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            insn_q  <= insn_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid        = valid_q;
    assign opcode           = insn_q[6:0];
    assign rd               = insn_q[11:7];
    assign funct3           = insn_q[14:12];
    assign rs1              = insn_q[19:15];
    assign rs2              = insn_q[24:20];
    assign funct7           = insn_q[31:25];
    assign shamt            = insn_q[24:20];
    assign imm              = ctrl_q.imm;
    assign alu_sel          = ctrl_q.alu_sel;
    assign wb_sel           = ctrl_q.wb_sel;
    assign A_sel            = ctrl_q.a_sel;
    assign B_sel            = ctrl_q.b_sel;
    assign reg_write_enable = ctrl_q.reg_we;
    assign br_un            = ctrl_q.br_un;
    assign mem_rw           = ctrl_q.mem_rw;
    assign pc_sel           = ctrl_q.pc_sel;
    assign access_size      = ctrl_q.access_size;
    assign load_un          = ctrl_q.load_un;

endmodule

// File: tb/tb_insn_decode_ctrl.sv
// Scoreboard bench for insn_decode_ctrl: the driver queues hand-computed expectations,
// a monitor pops and compares them whenever out_valid is high.
module tb_insn_decode_ctrl;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [1:0]  wb;
        logic [5:0]  flags;   // {A_sel, B_sel, reg_write_enable, br_un, mem_rw, pc_sel}
        logic [1:0]  asz;
        logic        lun;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] insn;
    logic        br_eq;
    logic        br_lt;
    logic        out_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [3:0]  alu_sel;
    logic [1:0]  wb_sel;
    logic        A_sel;
    logic        B_sel;
    logic        reg_write_enable;
    logic        br_un;
    logic        mem_rw;
    logic        pc_sel;
    logic [1:0]  access_size;
    logic        load_un;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    insn_decode_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .insn             (insn),
        .br_eq            (br_eq),
        .br_lt            (br_lt),
        .out_valid        (out_valid),
        .opcode           (opcode),
        .rd               (rd),
        .funct3           (funct3),
        .rs1              (rs1),
        .rs2              (rs2),
        .funct7           (funct7),
        .shamt            (shamt),
        .imm              (imm),
        .alu_sel          (alu_sel),
        .wb_sel           (wb_sel),
        .A_sel            (A_sel),
        .B_sel            (B_sel),
        .reg_write_enable (reg_write_enable),
        .br_un            (br_un),
        .mem_rw           (mem_rw),
        .pc_sel           (pc_sel),
        .access_size      (access_size),
        .load_un          (load_un)
    );

    function automatic exp_t mk(input logic [31:0] i, input logic [31:0] im,
                                input logic [3:0] al, input logic [1:0] wb,
                                input logic [5:0] fl, input logic [1:0] asz,
                                input logic lun);
        exp_t e;
        e.insn = i; e.imm = im; e.alu = al; e.wb = wb;
        e.flags = fl; e.asz = asz; e.lun = lun;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_now();
        return {17'd0, alu_sel, wb_sel, A_sel, B_sel, reg_write_enable, br_un,
                mem_rw, pc_sel, access_size, load_un};
    endfunction

    task automatic send(input logic [31:0] i, input logic eq, input logic lt, input exp_t e);
        @(negedge clk);
        in_valid = 1'b1;
        insn     = i;
        br_eq    = eq;
        br_lt    = lt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] i);
        @(negedge clk);
        in_valid = 1'b0;
        insn     = i;
    endtask

    // Monitor: pop on every valid output, otherwise require quiet controls.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("txn insn=%h imm=%h alu=%b wb=%b flags=%b asz=%b lun=%b",
                         e.insn, imm, alu_sel, wb_sel,
                         {A_sel, B_sel, reg_write_enable, br_un, mem_rw, pc_sel},
                         access_size, load_un);
                chk("fields", {funct7, rs2, rs1, funct3, rd, opcode}, e.insn);
                chk("shamt", {27'd0, shamt}, {27'd0, e.insn[24:20]});
                chk("imm", imm, e.imm);
                chk("ctrl", ctrl_now(), {17'd0, e.alu, e.wb, e.flags, e.asz, e.lun});
            end
        end else begin
            chk("idle_ctrl", ctrl_now(), 32'd0);
            chk("idle_imm", imm, 32'd0);
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        insn     = 32'h0;
        br_eq    = 1'b0;
        br_lt    = 1'b0;
        #2;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        send(32'h11412083, 1'b0, 1'b0, mk(32'h11412083, 32'h00000114, 4'b0000, 2'b00, 6'b011000, 2'b10, 1'b0)); // LW
        send(32'h40B50533, 1'b0, 1'b0, mk(32'h40B50533, 32'h00000000, 4'b1000, 2'b01, 6'b001000, 2'b00, 1'b0)); // SUB
        send(32'hFE0418E3, 1'b0, 1'b1, mk(32'hFE0418E3, 32'hFFFFFFF0, 4'b0000, 2'b01, 6'b110001, 2'b00, 1'b0)); // BNE taken
        send(32'hFE0418E3, 1'b1, 1'b0, mk(32'hFE0418E3, 32'hFFFFFFF0, 4'b0000, 2'b01, 6'b110000, 2'b00, 1'b0)); // BNE not taken
        send(32'hFE0468E3, 1'b0, 1'b1, mk(32'hFE0468E3, 32'hFFFFFFF0, 4'b0000, 2'b01, 6'b110101, 2'b00, 1'b0)); // BLTU taken
        send(32'hFE0458E3, 1'b0, 1'b1, mk(32'hFE0458E3, 32'hFFFFFFF0, 4'b0000, 2'b01, 6'b110000, 2'b00, 1'b0)); // BGE not taken
        send(32'h00112423, 1'b0, 1'b0, mk(32'h00112423, 32'h00000008, 4'b0000, 2'b01, 6'b010010, 2'b10, 1'b0)); // SW
        send(32'h00014083, 1'b0, 1'b0, mk(32'h00014083, 32'h00000000, 4'b0000, 2'b00, 6'b011000, 2'b00, 1'b1)); // LBU
        send(32'h123450B7, 1'b0, 1'b0, mk(32'h123450B7, 32'h12345000, 4'b1111, 2'b01, 6'b011000, 2'b00, 1'b0)); // LUI

        // Async reset while LUI results are still held on the outputs.
        idle(32'h40B50533);
        #2;
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_valid", {31'd0, out_valid}, 32'd0);
        chk("async_reset_imm", imm, 32'd0);
        chk("async_reset_ctrl", ctrl_now(), 32'd0);
        chk("async_reset_fields", {funct7, rs2, rs1, funct3, rd, opcode}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        send(32'h008000EF, 1'b0, 1'b0, mk(32'h008000EF, 32'h00000008, 4'b0000, 2'b10, 6'b111001, 2'b00, 1'b0)); // JAL
        send(32'h00000073, 1'b1, 1'b1, mk(32'h00000073, 32'h00000000, 4'b0000, 2'b00, 6'b000000, 2'b00, 1'b0)); // ECALL
        send(32'hFFFFFFFF, 1'b1, 1'b1, mk(32'hFFFFFFFF, 32'h00000000, 4'b0000, 2'b00, 6'b000000, 2'b00, 1'b0)); // invalid op
        send(32'h40335293, 1'b0, 1'b0, mk(32'h40335293, 32'h00000403, 4'b1101, 2'b01, 6'b011000, 2'b00, 1'b0)); // SRAI
        send(32'hC0000093, 1'b0, 1'b0, mk(32'hC0000093, 32'hFFFFFC00, 4'b0000, 2'b01, 6'b011000, 2'b00, 1'b0)); // ADDI -1024
        idle(32'h40B50533);
        send(32'hFFFFF197, 1'b0, 1'b0, mk(32'hFFFFF197, 32'hFFFFF000, 4'b0000, 2'b01, 6'b111000, 2'b00, 1'b0)); // AUIPC
        send(32'h00008067, 1'b0, 1'b0, mk(32'h00008067, 32'h00000000, 4'b0000, 2'b10, 6'b011001, 2'b00, 1'b0)); // JALR
        idle(32'h123450B7);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 32'd0);
        end
        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
